flash_read_arbiter: RTL and testbench
=====================================

// Module: flash_read_arbiter
// PURPOSE
//  Shares the single 16-bit boot/kernel flash slave between two read requesters:
//  port 0 (instruction fetch) and port 1 (data/load path). Grants one request at a
//  time, round-robin, and sequences the flash select/ready/address strobes with a
//  programmable wait. Assembles a 32-bit word from two flash halfword beats.
//  Sits between the CPU memory stage/fetch unit and the flash bus slave.
// PARAMETERS
//  WAIT_CYCLES  1  cycles from address strobe to readdata sample; legal range 1..15
//  WIDE         1  1: two beats (lo at A, hi at A+4) -> 32-bit word; 0: one beat, hi=0
// PORTS
//  Hclock        in   1   system clock; all state changes on its rising edge
//  Hreset        in   1   synchronous reset, active-high
//  m0_req        in   1   port 0 request; held with m0_addr/m0_write until m0_ack
//  m0_write      in   1   port 0 write intent (flash is read-only -> error)
//  m0_addr       in   24  port 0 byte address, word aligned
//  m0_rdata      out  32  port 0 read data; valid while m0_ack=1, then held
//  m0_ack        out  1   port 0 one-cycle completion pulse
//  m0_err        out  1   port 0 error, valid only with m0_ack
//  m1_req/m1_write/m1_addr/m1_rdata/m1_ack/m1_err  same as port 0, for port 1
//  f_select      out  1   flash Hselect
//  f_ready       out  1   flash address-latch strobe (flash "ready" input)
//  f_write       out  1   flash Hwrite; constant 0
//  f_size        out  1   flash Hsize; constant 0
//  f_address     out  24  flash Haddress
//  f_writedata   out  32  flash Hwritedata; constant 0
//  f_readdata    in   32  flash Hreaddata; only [15:0] used
//  f_hready      in   1   flash Hready; captured beat is discarded if 0 at sample
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (port 0 wins first tie), all outputs 0,
//   m0_rdata=m1_rdata=0. Reset in any state aborts the access at once; no ack issued.
//  States: IDLE, ADDR_LO, WAIT_LO, ADDR_HI, WAIT_HI, DONE, ERR.
//  IDLE: sample m0_req/m1_req. One requesting -> grant it; both -> grant the port
//   not in last_grant; update last_grant. Latch grant addr into addr_q.
//   If granted port has write=1 or addr[1:0]!=0 -> ERR; else -> ADDR_LO.
//  ADDR_LO: f_select=f_ready=1, f_address=addr_q (one cycle) -> WAIT_LO.
//  WAIT_LO: f_select=1, f_ready=0, f_address held; counter runs WAIT_CYCLES cycles;
//   on the last one capture lo=f_readdata[15:0]. If f_hready=0 there, restart
//   count (stay WAIT_LO). Then -> ADDR_HI if WIDE=1, else DONE.
//  ADDR_HI/WAIT_HI: as LO with f_address=addr_q+24'd4 (wraps mod 2^24), capture hi.
//  DONE: granted port ack=1, rdata={hi,lo} (hi=0 when WIDE=0), err=0 -> IDLE.
//  ERR: granted port ack=1, err=1, rdata unchanged -> IDLE. No flash strobes.
//  Latency (f_hready=1): req sampled in IDLE at cycle 0 -> ack at cycle 2W+3
//   (WIDE=1) or W+2 (WIDE=0); ERR ack at cycle 1. W=WAIT_CYCLES.
//  Back-to-back: IDLE is always visited for one cycle between accesses; a
//   requester dropping req after ack and re-raising is re-arbitrated normally.
//  Ungranted port sees ack=0, err=0; its req is ignored until next IDLE.
//  Requester changing addr/write mid-access: no effect (addr_q latched in IDLE).
//  ack/err are never asserted on both ports in the same cycle.
// TESTING
//  1 Reset then m0_req, addr=0x000010, flash[4]=0x1234, flash[5]=0xABCD, W=1
//    -> f_address 0x10 then 0x14, m0_ack at cycle 5, m0_rdata=0xABCD1234.
//  2 m0_req and m1_req raised same cycle, held -> grants m0, m1, m0, m1
//    in order; acks alternate, never overlap.
//  3 m1_req, m1_write=1 -> m1_ack=1,m1_err=1 at cycle 1; f_select stays 0.
//  4 m0_addr=0x000006 (misaligned) -> m0_err=1 at cycle 1; rdata unchanged.
//  5 Assert Hreset during WAIT_HI -> next cycle all outputs 0, no ack; new
//    request after reset completes with correct data.
//  6 WIDE=0, W=3, addr=0xFFFFFC -> ack at cycle 5, rdata={16'h0,flash[0x3FFFFF]};
//    with WIDE=1 hi beat address wraps to 0x000000.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// Round-robin read arbiter that shares one 16-bit flash slave between two requesters.
// Each granted read is one or two halfword beats with a programmable wait before sampling.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrate, latch granted address
// ADDR_LO   | strobe low-beat address into flash
// WAIT_LO   | count wait cycles, capture low halfword
// ADDR_HI   | strobe high-beat address (addr+4) into flash
// WAIT_HI   | count wait cycles, capture high halfword
// DONE      | ack granted port with assembled word
// ERR       | ack granted port with error (write or misaligned)
module flash_read_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter bit WIDE        = 1'b1
) (
    input  logic        Hclock,
    input  logic        Hreset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [23:0] m0_addr,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [23:0] m1_addr,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        f_select,
    output logic        f_ready,
    output logic        f_write,
    output logic        f_size,
    output logic [23:0] f_address,
    output logic [31:0] f_writedata,
    input  logic [31:0] f_readdata,
    input  logic        f_hready
);

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, WAIT_LO, ADDR_HI, WAIT_HI, DONE, ERR
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state, next_state;
    logic        grant_q, last_grant, grant_d;
    logic [23:0] addr_q, sel_addr;
    logic        sel_write, req_any;
    logic [3:0]  cnt;
    logic [15:0] lo_q;
    logic [31:0] rdata0_q, rdata1_q, result;
    logic        result_load, beat_done, ack_any, err_any;
    logic        unused_readdata;

    assign unused_readdata = ^f_readdata[31:16];

    assign req_any   = m0_req | m1_req;
    assign beat_done = (cnt == 4'd0) && f_hready;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_d = 1'b0;
        if (m0_req && m1_req)
            grant_d = ~last_grant;
        else if (m1_req)
            grant_d = 1'b1;
        sel_addr  = grant_d ? m1_addr  : m0_addr;
        sel_write = grant_d ? m1_write : m0_write;
    end

    always_comb begin
        next_state  = state;
        f_select    = 1'b0;
        f_ready     = 1'b0;
        f_address   = 24'h0;
        ack_any     = 1'b0;
        err_any     = 1'b0;
        result_load = 1'b0;
        result      = 32'h0;
        case (state)
            IDLE: begin
                if (req_any)
                    next_state = (sel_write || sel_addr[1:0] != 2'b00) ? ERR : ADDR_LO;
            end
            ADDR_LO: begin
                f_select   = 1'b1;
                f_ready    = 1'b1;
                f_address  = addr_q;
                next_state = WAIT_LO;
            end
            WAIT_LO: begin
                f_select  = 1'b1;
                f_address = addr_q;
                if (beat_done) begin
                    next_state = WIDE ? ADDR_HI : DONE;
                    if (!WIDE) begin
                        result_load = 1'b1;
                        result      = {16'h0, f_readdata[15:0]};
                    end
                end
            end
            ADDR_HI: begin
                f_select   = 1'b1;
                f_ready    = 1'b1;
                f_address  = addr_q + 24'd4;
                next_state = WAIT_HI;
            end
            WAIT_HI: begin
                f_select  = 1'b1;
                f_address = addr_q + 24'd4;
                if (beat_done) begin
                    next_state  = DONE;
                    result_load = 1'b1;
                    result      = {f_readdata[15:0], lo_q};
                end
            end
            DONE: begin
                ack_any    = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                ack_any    = 1'b1;
                err_any    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Hclock) begin
        if (Hreset) begin
            state      <= IDLE;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= 24'h0;
            cnt        <= 4'd0;
            lo_q       <= 16'h0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_any) begin
                grant_q    <= grant_d;
                last_grant <= grant_d;
                addr_q     <= sel_addr;
            end
            if (state == ADDR_LO || state == ADDR_HI)
                cnt <= CNT_LOAD;
            else if (state == WAIT_LO || state == WAIT_HI)
                // Terminal count without f_hready reloads, so the beat is retried in full.
                cnt <= (cnt == 4'd0) ? CNT_LOAD : cnt - 4'd1;
            if (state == WAIT_LO && beat_done)
                lo_q <= f_readdata[15:0];
            if (result_load) begin
                if (grant_q)
                    rdata1_q <= result;
                else
                    rdata0_q <= result;
            end
        end
    end

    assign m0_ack      = ack_any & ~grant_q;
    assign m0_err      = err_any & ~grant_q;
    assign m1_ack      = ack_any & grant_q;
    assign m1_err      = err_any & grant_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign f_write     = 1'b0;
    assign f_size      = 1'b0;
    assign f_writedata = 32'h0;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: instance a (W=1, two beats) and instance b (W=3, one beat).
// Flash is modelled as a halfword table indexed by address[23:2]; junk is returned while hready=0.
module tb_flash_read_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        a_m0_req, a_m0_write, a_m1_req, a_m1_write, a_hready;
    logic [23:0] a_m0_addr, a_m1_addr, a_faddr;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_fwdata, a_frdata;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic        a_fsel, a_fready, a_fwrite, a_fsize;

    logic        b_m0_req, b_m0_write, b_m1_req, b_m1_write, b_hready;
    logic [23:0] b_m0_addr, b_m1_addr, b_faddr;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_fwdata, b_frdata;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic        b_fsel, b_fready, b_fwrite, b_fsize;

    function automatic logic [15:0] fd(input logic [23:0] a);
        logic [21:0] idx;
        idx = a[23:2];
        case (idx)
            22'd4:        fd = 16'h1234;
            22'd5:        fd = 16'hABCD;
            22'd0:        fd = 16'h0F0F;
            22'h3FFFFF:   fd = 16'hC3C3;
            default:      fd = idx[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign a_frdata = a_hready ? {16'hDEAD, fd(a_faddr)} : 32'hFFFF_EEEE;
    assign b_frdata = b_hready ? {16'hDEAD, fd(b_faddr)} : 32'hFFFF_EEEE;

    flash_read_arbiter #(.WAIT_CYCLES(1), .WIDE(1'b1)) dut_a (
        .Hclock(clk), .Hreset(rst),
        .m0_req(a_m0_req), .m0_write(a_m0_write), .m0_addr(a_m0_addr),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
        .m1_req(a_m1_req), .m1_write(a_m1_write), .m1_addr(a_m1_addr),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
        .f_select(a_fsel), .f_ready(a_fready), .f_write(a_fwrite), .f_size(a_fsize),
        .f_address(a_faddr), .f_writedata(a_fwdata), .f_readdata(a_frdata),
        .f_hready(a_hready)
    );

    flash_read_arbiter #(.WAIT_CYCLES(3), .WIDE(1'b0)) dut_b (
        .Hclock(clk), .Hreset(rst),
        .m0_req(b_m0_req), .m0_write(b_m0_write), .m0_addr(b_m0_addr),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
        .m1_req(b_m1_req), .m1_write(b_m1_write), .m1_addr(b_m1_addr),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
        .f_select(b_fsel), .f_ready(b_fready), .f_write(b_fwrite), .f_size(b_fsize),
        .f_address(b_faddr), .f_writedata(b_fwdata), .f_readdata(b_frdata),
        .f_hready(b_hready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while instance a is in IDLE; returns at the ack negedge.
    task automatic run_a(input int port, input logic [23:0] addr, input logic wr,
                         input int exp_cyc, input logic exp_err, input logic [31:0] exp_rd,
                         input string tag);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 0;
        if (port == 0) begin
            a_m0_req = 1'b1; a_m0_addr = addr; a_m0_write = wr;
        end else begin
            a_m1_req = 1'b1; a_m1_addr = addr; a_m1_write = wr;
        end
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if ((port == 0) ? a_m0_ack : a_m1_ack) got = 1;
        end
        a_m0_req = 1'b0; a_m0_write = 1'b0;
        a_m1_req = 1'b0; a_m1_write = 1'b0;
        chk({tag, "_cycle"}, cyc, exp_cyc);
        if (port == 0) begin
            chk({tag, "_err"}, {31'h0, a_m0_err}, {31'h0, exp_err});
            chk({tag, "_rdata"}, a_m0_rdata, exp_rd);
            chk({tag, "_other_ack"}, {31'h0, a_m1_ack}, 32'h0);
        end else begin
            chk({tag, "_err"}, {31'h0, a_m1_err}, {31'h0, exp_err});
            chk({tag, "_rdata"}, a_m1_rdata, exp_rd);
            chk({tag, "_other_ack"}, {31'h0, a_m0_ack}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_m0_req = 0; a_m0_write = 0; a_m0_addr = 0;
        a_m1_req = 0; a_m1_write = 0; a_m1_addr = 0; a_hready = 1;
        b_m0_req = 0; b_m0_write = 0; b_m0_addr = 0;
        b_m1_req = 0; b_m1_write = 0; b_m1_addr = 0; b_hready = 1;
        repeat (3) @(negedge clk);
        chk("rst_fsel", {31'h0, a_fsel}, 32'h0);
        chk("rst_ack", {30'h0, a_m0_ack, a_m1_ack}, 32'h0);
        chk("rst_rdata0", a_m0_rdata, 32'h0);
        chk("rst_faddr", {8'h0, a_faddr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // basic two-beat read, cycle by cycle
        a_m0_req = 1'b1; a_m0_addr = 24'h000010;
        @(negedge clk);
        chk("t1_c1_strobe", {30'h0, a_fsel, a_fready}, 32'h3);
        chk("t1_c1_addr", {8'h0, a_faddr}, 32'h10);
        @(negedge clk);
        chk("t1_c2_strobe", {30'h0, a_fsel, a_fready}, 32'h2);
        chk("t1_c2_addr", {8'h0, a_faddr}, 32'h10);
        @(negedge clk);
        chk("t1_c3_strobe", {30'h0, a_fsel, a_fready}, 32'h3);
        chk("t1_c3_addr", {8'h0, a_faddr}, 32'h14);
        @(negedge clk);
        chk("t1_c4_ack", {31'h0, a_m0_ack}, 32'h0);
        @(negedge clk);
        chk("t1_c5_ack", {30'h0, a_m0_ack, a_m0_err}, 32'h2);
        chk("t1_c5_rdata", a_m0_rdata, 32'hABCD1234);
        a_m0_req = 1'b0;
        @(negedge clk);

        // misaligned -> error at cycle 1, rdata kept
        run_a(0, 24'h000006, 1'b0, 1, 1'b1, 32'hABCD1234, "t4");
        @(negedge clk);
        // write intent -> error at cycle 1, flash untouched
        run_a(1, 24'h000100, 1'b1, 1, 1'b1, 32'h0, "t3");
        chk("t3_fsel", {31'h0, a_fsel}, 32'h0);
        @(negedge clk);

        // both requesting and held: m0, m1, m0, m1
        a_m0_req = 1'b1; a_m0_addr = 24'h000020;
        a_m1_req = 1'b1; a_m1_addr = 24'h000030;
        for (int k = 0; k < 4; k++) begin
            int cyc;
            bit got;
            cyc = 0;
            got = 0;
            while (!got && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (a_m0_ack || a_m1_ack) got = 1;
            end
            chk($sformatf("t2_g%0d_cycle", k), cyc, (k == 0) ? 5 : 6);
            chk($sformatf("t2_g%0d_port", k), {31'h0, a_m1_ack}, (k % 2));
            chk($sformatf("t2_g%0d_overlap", k), {31'h0, a_m0_ack & a_m1_ack}, 32'h0);
            if (k % 2 == 0)
                chk($sformatf("t2_g%0d_rdata", k), a_m0_rdata, {fd(24'h24), fd(24'h20)});
            else
                chk($sformatf("t2_g%0d_rdata", k), a_m1_rdata, {fd(24'h34), fd(24'h30)});
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        @(negedge clk);

        // hready low at low-beat sample: beat discarded, ack one cycle later
        a_m1_req = 1'b1; a_m1_addr = 24'h000050;
        repeat (2) @(negedge clk);
        a_hready = 1'b0;
        @(negedge clk);
        a_hready = 1'b1;
        chk("th_c3_strobe", {30'h0, a_fsel, a_fready}, 32'h2);
        chk("th_c3_addr", {8'h0, a_faddr}, 32'h50);
        @(negedge clk);
        chk("th_c4_addr", {8'h0, a_faddr}, 32'h54);
        @(negedge clk);
        chk("th_c5_ack", {31'h0, a_m1_ack}, 32'h0);
        @(negedge clk);
        chk("th_c6_ack", {31'h0, a_m1_ack}, 32'h1);
        chk("th_c6_rdata", a_m1_rdata, {fd(24'h54), fd(24'h50)});
        a_m1_req = 1'b0;
        @(negedge clk);

        // reset during WAIT_HI aborts without ack
        a_m0_req = 1'b1; a_m0_addr = 24'h000040;
        repeat (4) @(negedge clk);
        chk("t5_c4_addr", {8'h0, a_faddr}, 32'h44);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_outs", {28'h0, a_m0_ack, a_m0_err, a_fsel, a_fready}, 32'h0);
        chk("t5_rst_faddr", {8'h0, a_faddr}, 32'h0);
        chk("t5_rst_rdata", a_m0_rdata, 32'h0);
        a_m0_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        run_a(0, 24'h000040, 1'b0, 5, 1'b0, {fd(24'h44), fd(24'h40)}, "t5b");
        @(negedge clk);

        // two-beat read with hi address wrapping to zero
        a_m0_req = 1'b1; a_m0_addr = 24'hFFFFFC;
        @(negedge clk);
        chk("t6a_c1_addr", {8'h0, a_faddr}, 32'h00FFFFFC);
        repeat (2) @(negedge clk);
        chk("t6a_c3_addr", {8'h0, a_faddr}, 32'h0);
        repeat (2) @(negedge clk);
        chk("t6a_c5_ack", {31'h0, a_m0_ack}, 32'h1);
        chk("t6a_c5_rdata", a_m0_rdata, 32'h0F0FC3C3);
        a_m0_req = 1'b0;

        // single-beat instance with W=3
        b_m0_req = 1'b1; b_m0_addr = 24'hFFFFFC;
        @(negedge clk);
        chk("t6b_c1_strobe", {30'h0, b_fsel, b_fready}, 32'h3);
        repeat (3) @(negedge clk);
        chk("t6b_c4_ack", {31'h0, b_m0_ack}, 32'h0);
        chk("t6b_c4_addr", {8'h0, b_faddr}, 32'h00FFFFFC);
        @(negedge clk);
        chk("t6b_c5_ack", {30'h0, b_m0_ack, b_m0_err}, 32'h2);
        chk("t6b_c5_rdata", b_m0_rdata, 32'h0000C3C3);
        b_m0_req = 1'b0;
        @(negedge clk);
        chk("t6b_idle_fsel", {31'h0, b_fsel}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
